ram_param: RTL and testbench
============================

# ram_param

Parametrised synchronous single-port RAM: the next generation of the team's 8x8 SRAM, generalised in data width, address width and depth. Adds an asynchronous active-low reset, a hardware clear engine that fills the array after reset or on request, a configurable read pipeline (1 or 2 cycles) with a `dataValid` strobe, and an optional write-through mode. It sits as a local scratch/lookup memory behind a simple chip-select/write-enable master.

## Interface
Parameters:
- `DATA_W`, 8: word width in bits.
- `ADDR_W`, 3: address width.
- `DEPTH`, 8: number of words; legal range 2 ≤ DEPTH ≤ 2**ADDR_W.
- `RD_LAT`, 1: read latency in cycles; legal values are 1 and 2.
- `WR_THRU`, 0: 1 means a write also returns the written word on `dataOut` with `dataValid`.
- `CLR_VAL`, 0: `DATA_W`-bit value written to every word by the clear engine.

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Rst_n`  in  1  asynchronous active-low reset.
- `CS`  in  1  chip select; when high, an access is requested this cycle.
- `WE`  in  1  1 = write, 0 = read; qualified by `CS`.
- `Addr`  in  ADDR_W  word address.
- `dataIn`  in  DATA_W  write data.
- `Clr`  in  1  single-cycle pulse that restarts the clear engine.
- `dataOut`  out  DATA_W  read data; holds its value between accesses.
- `dataValid`  out  1  one-cycle strobe marking new `dataOut`.
- `Busy`  out  1  high while the clear engine runs; accesses are ignored while it is high.

## Operation
- **Reset values:** while `Rst_n`=0, `dataOut`=0, `dataValid`=0, `Busy`=1, FSM in CLEAR, clear counter=0, and the read pipeline is flushed. Array contents are not reset directly; the clear engine initialises them.
- **FSM:** two states, CLEAR and IDLE.
  - CLEAR: writes `CLR_VAL` to address `clr_cnt` each cycle, for `clr_cnt` = 0..DEPTH-1. After the write to DEPTH-1 it moves to IDLE. `Busy`=1 throughout.
  - IDLE: `Busy`=0. `Clr`=1 moves the FSM to CLEAR with `clr_cnt`=0.
- **Inputs ignored during CLEAR:** `CS`, `WE` and `Clr` have no effect. They are not queued.
- **Clr priority in IDLE:** if `Clr`=1 and `CS`=1 in the same IDLE cycle, `Clr` wins and the access is dropped (no write, no `dataValid`).
- **Read** (IDLE, `CS`=1, `WE`=0): the word at `Addr` goes into the read pipeline.
- **Write** (IDLE, `CS`=1, `WE`=1): `dataIn` is stored at `Addr`.
  - `WR_THRU`=1: `dataIn` also goes into the read pipeline as if it were read data.
  - `WR_THRU`=0: the write produces no `dataValid`.
- **Out-of-range address** (`Addr` ≥ DEPTH): a write is dropped. A read returns `CLR_VAL` with a normal `dataValid`.
- **Idle cycles** (`CS`=0): no array access. `dataOut` holds its last value and `dataValid`=0. This replaces the old drive-to-x behaviour.
- **Read pipeline:** a shift of `RD_LAT` stages, each stage holding a valid bit and a data word. `dataOut` updates only when a valid word leaves the last stage.
- **Mid-operation events:**
  - Reset asserted mid-clear: the clear restarts from address 0 after release.
  - Reads already in flight when `Clr` is accepted still complete normally.

## Timing
- **Read latency:** an access sampled at rising edge k drives `dataOut` and `dataValid`=1 during the cycle after edge k+RD_LAT-1.
  - RD_LAT=1: visible in the cycle after edge k.
  - RD_LAT=2: visible one cycle later than that.
- **Throughput:** one access per cycle. Back-to-back reads give back-to-back `dataValid` pulses with no bubbles.
- **Read/write sequencing:**
  - Read-after-write to the same address on the next edge returns the new data.
  - The array is single-port, so there is no same-cycle read-during-write.
- **Clear duration:** exactly DEPTH cycles.
  - After `Rst_n` rises, the first rising edge writes address 0.
  - `Busy` falls after the edge that writes address DEPTH-1.
  - The first access accepted is the one sampled at the next edge.
- **After `Clr` accepted at edge k:** `Busy`=1 from edge k to edge k+DEPTH. Accesses are accepted again from edge k+DEPTH+1.

## Test plan
- **Reset and clear:** deassert `Rst_n`, count `Busy` cycles, then read all addresses (defaults: DATA_W=8, ADDR_W=3, DEPTH=8, RD_LAT=1) -> `Busy` high for exactly 8 cycles; every read returns 0 with one `dataValid` pulse each.
- **Write/read sweep:** write 30..37 to addresses 0..7, then read addresses 0..4 back-to-back -> `dataOut` = 30,31,32,33,34 on consecutive cycles, `dataValid` high for 5 cycles; no `dataValid` during the writes.
- **Deselect hold:** read address 1 (returns 31), then hold `CS`=0 for 10 cycles -> `dataOut` stays 31, `dataValid`=0; never x.
- **RD_LAT=2 with WR_THRU=1:**
  - Write 0x5A to address 2 -> 0x5A appears with `dataValid` 2 cycles later.
  - Immediate read of address 2 -> 0x5A on the next cycle.
- **Clr collision:** pulse `Clr` together with a write of 40 to address 0, then read address 0 after `Busy` falls -> the write is dropped, the read returns `CLR_VAL`, and `Busy` lasts DEPTH cycles.
- **Edge cases:** with DEPTH=6, ADDR_W=3:
  - Write 0x77 to address 7, then read address 7 -> `CLR_VAL` returned with `dataValid`.
  - Assert `Rst_n`=0 mid-clear -> outputs return to reset values at once, and the clear reruns for 6 full cycles.

Source files
------------

// File: rtl/ram_param_if.sv
// Access bus for ram_param: chip-select/write-enable requests from a master,
// read data, valid strobe and clear-engine status back from the RAM.
interface ram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              CS;
    logic              WE;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] dataIn;
    logic              Clr;
    logic [DATA_W-1:0] dataOut;
    logic              dataValid;
    logic              Busy;

    modport master (
        output CS, WE, Addr, dataIn, Clr,
        input  dataOut, dataValid, Busy
    );

    modport slave (
        input  CS, WE, Addr, dataIn, Clr,
        output dataOut, dataValid, Busy
    );
endinterface

// File: rtl/ram_param.sv
// Parametrised single-port RAM with hardware clear engine, 1- or 2-stage
// read pipeline with valid strobe, and optional write-through.
module ram_param #(
    parameter int                DATA_W  = 8,
    parameter int                ADDR_W  = 3,
    parameter int                DEPTH   = 8,
    parameter int                RD_LAT  = 1,
    parameter int                WR_THRU = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
    input  logic     Clk,
    input  logic     Rst_n,
    ram_param_if.slave bus
);
    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_range;
    logic              acc;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;
    logic              pipe_in_vld;
    logic [DATA_W-1:0] pipe_in_dat;

    logic [RD_LAT-1:0] vld;
    logic [DATA_W-1:0] dat [RD_LAT];

    assign in_range = {1'b0, bus.Addr} < DEPTH_L;
    assign rd_word  = in_range ? mem[bus.Addr] : CLR_VAL;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= cnt_nxt;
        end
    end

    // Clr outranks a same-cycle access; nothing is accepted while clearing
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = clr_cnt;
        acc         = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = bus.Addr;
        mem_wdata   = bus.dataIn;
        unique case (state)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_cnt;
                mem_wdata = CLR_VAL;
                cnt_nxt   = clr_cnt + 1'b1;
                if (clr_cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            end
            IDLE: begin
                if (bus.Clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end else if (bus.CS) begin
                    acc    = 1'b1;
                    mem_we = bus.WE & in_range;
                end
            end
        endcase
        pipe_in_vld = acc & (~bus.WE | (WR_THRU != 0));
        pipe_in_dat = bus.WE ? bus.dataIn : rd_word;
    end

    always_ff @(posedge Clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    // Each stage keeps its word when no valid entry arrives, so the
    // last stage doubles as the holding output register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LAT; i++)
                dat[i] <= '0;
        end else begin
            vld[0] <= pipe_in_vld;
            if (pipe_in_vld)
                dat[0] <= pipe_in_dat;
            for (int i = 1; i < RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1])
                    dat[i] <= dat[i-1];
            end
        end
    end

    assign bus.dataOut   = dat[RD_LAT-1];
    assign bus.dataValid = vld[RD_LAT-1];
    assign bus.Busy      = (state == CLEAR);
endmodule

// File: tb/tb_ram_param.sv
// Directed bench for ram_param: default config, RD_LAT=2 write-through
// config, and a DEPTH=6 config with out-of-range and mid-clear reset.
module tb_ram_param;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   checks = 0;
    int   errors = 0;
    int   na, nb, nc, n;

    always #5 clk = ~clk;

    ram_param_if #(.DATA_W(8), .ADDR_W(3)) ia ();
    ram_param_if #(.DATA_W(8), .ADDR_W(3)) ib ();
    ram_param_if #(.DATA_W(8), .ADDR_W(3)) ic ();

    ram_param #(
        .DATA_W(8), .ADDR_W(3), .DEPTH(8), .RD_LAT(1),
        .WR_THRU(0), .CLR_VAL(8'h00)
    ) u_a (.Clk(clk), .Rst_n(rst_a), .bus(ia));

    ram_param #(
        .DATA_W(8), .ADDR_W(3), .DEPTH(8), .RD_LAT(2),
        .WR_THRU(1), .CLR_VAL(8'hA5)
    ) u_b (.Clk(clk), .Rst_n(rst_b), .bus(ib));

    ram_param #(
        .DATA_W(8), .ADDR_W(3), .DEPTH(6), .RD_LAT(1),
        .WR_THRU(0), .CLR_VAL(8'h3C)
    ) u_c (.Clk(clk), .Rst_n(rst_c), .bus(ic));

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(logic cs, logic we, logic [2:0] a, logic [7:0] d);
        ia.CS = cs; ia.WE = we; ia.Addr = a; ia.dataIn = d;
    endtask

    task automatic set_b(logic cs, logic we, logic [2:0] a, logic [7:0] d);
        ib.CS = cs; ib.WE = we; ib.Addr = a; ib.dataIn = d;
    endtask

    task automatic set_c(logic cs, logic we, logic [2:0] a, logic [7:0] d);
        ic.CS = cs; ic.WE = we; ic.Addr = a; ic.dataIn = d;
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ia.Clr = 1'b0; ib.Clr = 1'b0; ic.Clr = 1'b0;
        set_a(0, 0, 0, 0); set_b(0, 0, 0, 0); set_c(0, 0, 0, 0);
        tick; tick;
        check("rst_dout", ia.dataOut, 8'h00);
        check("rst_valid", 8'(ia.dataValid), 8'h00);
        check("rst_busy_a", 8'(ia.Busy), 8'h01);
        check("rst_busy_c", 8'(ic.Busy), 8'h01);

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        na = 0; nb = 0; nc = 0;
        for (int i = 0; i < 20; i++) begin
            na += int'(ia.Busy);
            nb += int'(ib.Busy);
            nc += int'(ic.Busy);
            tick;
        end
        check("clr_len_a", 8'(na), 8'd8);
        check("clr_len_b", 8'(nb), 8'd8);
        check("clr_len_c", 8'(nc), 8'd6);

        for (int i = 0; i < 8; i++) begin
            set_a(1, 0, 3'(i), 0);
            tick;
            check("init_rd_valid", 8'(ia.dataValid), 8'h01);
            check("init_rd_data", ia.dataOut, 8'h00);
        end

        for (int i = 0; i < 8; i++) begin
            set_a(1, 1, 3'(i), 8'(30 + i));
            tick;
            check("wr_no_valid", 8'(ia.dataValid), 8'h00);
        end
        for (int i = 0; i < 5; i++) begin
            set_a(1, 0, 3'(i), 0);
            tick;
            check("sweep_valid", 8'(ia.dataValid), 8'h01);
            check("sweep_data", ia.dataOut, 8'(30 + i));
        end

        set_a(1, 0, 3'd1, 0);
        tick;
        check("rd1_data", ia.dataOut, 8'd31);
        set_a(0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick;
            check("hold_data", ia.dataOut, 8'd31);
            check("hold_valid", 8'(ia.dataValid), 8'h00);
        end

        ia.Clr = 1'b1;
        set_a(1, 1, 3'd0, 8'd40);
        tick;
        ia.Clr = 1'b0;
        set_a(1, 1, 3'd3, 8'h99);
        n = 0;
        while (ia.Busy && n < 50) begin
            n++;
            check("busy_no_valid", 8'(ia.dataValid), 8'h00);
            tick;
        end
        check("clr_busy_len", 8'(n), 8'd8);
        set_a(1, 0, 3'd0, 0);
        tick;
        check("coll_valid", 8'(ia.dataValid), 8'h01);
        check("coll_data", ia.dataOut, 8'h00);
        set_a(1, 0, 3'd3, 0);
        tick;
        check("ign_wr_data", ia.dataOut, 8'h00);
        set_a(0, 0, 0, 0);

        set_b(1, 0, 3'd3, 0);
        tick;
        check("b_rd_lat1", 8'(ib.dataValid), 8'h00);
        set_b(0, 0, 0, 0);
        tick;
        check("b_rd_valid", 8'(ib.dataValid), 8'h01);
        check("b_rd_clrval", ib.dataOut, 8'hA5);
        set_b(1, 1, 3'd2, 8'h5A);
        tick;
        check("b_wt_early", 8'(ib.dataValid), 8'h00);
        set_b(1, 0, 3'd2, 0);
        tick;
        check("b_wt_valid", 8'(ib.dataValid), 8'h01);
        check("b_wt_data", ib.dataOut, 8'h5A);
        set_b(0, 0, 0, 0);
        tick;
        check("b_raw_valid", 8'(ib.dataValid), 8'h01);
        check("b_raw_data", ib.dataOut, 8'h5A);
        tick;
        check("b_idle_valid", 8'(ib.dataValid), 8'h00);
        check("b_idle_data", ib.dataOut, 8'h5A);

        set_c(1, 1, 3'd7, 8'h77);
        tick;
        check("c_oor_wr", 8'(ic.dataValid), 8'h00);
        set_c(1, 0, 3'd7, 0);
        tick;
        check("c_oor_valid", 8'(ic.dataValid), 8'h01);
        check("c_oor_data", ic.dataOut, 8'h3C);
        set_c(1, 1, 3'd5, 8'h55);
        tick;
        set_c(1, 0, 3'd5, 0);
        tick;
        check("c_last_data", ic.dataOut, 8'h55);
        set_c(1, 1, 3'd6, 8'h66);
        tick;
        set_c(1, 0, 3'd6, 0);
        tick;
        check("c_a6_data", ic.dataOut, 8'h3C);
        set_c(0, 0, 0, 0);

        ic.Clr = 1'b1;
        tick;
        ic.Clr = 1'b0;
        tick; tick;
        rst_c = 1'b0;
        #1;
        check("c_mid_busy", 8'(ic.Busy), 8'h01);
        check("c_mid_dout", ic.dataOut, 8'h00);
        check("c_mid_valid", 8'(ic.dataValid), 8'h00);
        tick;
        rst_c = 1'b1;
        n = 0;
        while (ic.Busy && n < 50) begin
            n++;
            tick;
        end
        check("c_reclr_len", 8'(n), 8'd6);
        set_c(1, 0, 3'd5, 0);
        tick;
        check("c_reclr_data", ic.dataOut, 8'h3C);
        set_c(0, 0, 0, 0);
        tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
